// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the RAM-bank arbiter: FSM states, owners, bus geometry.
package mem_access_arbiter_pkg;

    localparam int DATA_W    = 16;
    localparam int WORD_W    = 10;
    localparam int BANK_MSB  = 11;
    localparam int BANK_LSB  = 10;
    localparam int NUM_BANKS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_WB  = 1'b1
    } owner_e;

    // One-hot-low chip select for the addressed bank.
    function automatic logic [NUM_BANKS-1:0] bank_csb(input logic [BANK_MSB-BANK_LSB:0] bank);
        bank_csb = ~(NUM_BANKS'(1) << bank);
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Two-requester grant (CPU vs Wishbone) with a last_grant register for round-robin.
module mem_arb_grant
    import mem_access_arbiter_pkg::*;
#(
    parameter bit RR_ARB = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   cpu_req,
    input  logic   wb_req,
    input  logic   take,
    output logic   grant_valid,
    output owner_e grant_owner
);

    owner_e last_grant_q;
    owner_e last_grant_d;

    // Pick the winner: a lone requester wins; a tie goes to the CPU unless round-robin says otherwise.
    always_comb begin
        grant_valid = cpu_req | wb_req;
        grant_owner = OWNER_CPU;
        if (cpu_req && wb_req) begin
            if (RR_ARB && (last_grant_q == OWNER_CPU)) begin
                grant_owner = OWNER_WB;
            end
        end else if (wb_req) begin
            grant_owner = OWNER_WB;
        end
        last_grant_d = (take && grant_valid) ? grant_owner : last_grant_q;
    end

    // Remember who was served last; reset favours the CPU on the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= OWNER_WB;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares four 1K x 16 RAM banks between the CPU port and a Wishbone slave window.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter logic [31:0] WB_BASE = 32'h3000_0000,
    parameter bit          RR_ARB  = 1'b1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    input  logic                 cpu_en,
    input  logic                 cpu_rw,
    input  logic [BANK_MSB:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_ready,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic [WORD_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_din,
    input  logic [DATA_W-1:0]    mem_dout,
    output logic [NUM_BANKS-1:0] mem_csb,
    output logic                 mem_web,
    output logic                 busy
);

    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  write_q, write_d;
    logic [WORD_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     din_q, din_d;
    logic [NUM_BANKS-1:0]  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [DATA_W-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]     wb_rdata_q, wb_rdata_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic                  wbs_ack_q, wbs_ack_d;

    logic   wb_hit;
    logic   wb_req;
    logic   wb_lanes_ok;
    logic   wb_aborted;
    logic   grant_take;
    logic   grant_valid;
    owner_e grant_owner;
    logic   unused_bits;

    assign wb_hit      = (wbs_adr_i[31:14] == WB_BASE[31:14]);
    assign wb_req      = wbs_cyc_i & wbs_stb_i & wb_hit;
    assign wb_lanes_ok = (wbs_sel_i[1:0] == 2'b11);
    assign wb_aborted  = (owner_q == OWNER_WB) && !(wbs_cyc_i && wbs_stb_i);
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:DATA_W], wbs_sel_i[3:2]};

    mem_arb_grant #(
        .RR_ARB (RR_ARB)
    ) u_grant (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_n),
        .cpu_req     (cpu_en),
        .wb_req      (wb_req),
        .take        (grant_take),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Next-state and datapath: latch the winner in IDLE, strobe the RAM for one cycle, then hand back.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        write_d     = write_q;
        addr_d      = addr_q;
        din_d       = din_q;
        csb_d       = '1;
        web_d       = 1'b1;
        cpu_rdata_d = cpu_rdata_q;
        wb_rdata_d  = wb_rdata_q;
        cpu_ready_d = 1'b0;
        wbs_ack_d   = 1'b0;
        grant_take  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    grant_take = 1'b1;
                    owner_d    = grant_owner;
                    state_d    = ST_ACCESS;
                    if (grant_owner == OWNER_CPU) begin
                        write_d = cpu_rw;
                        addr_d  = cpu_addr[WORD_W-1:0];
                        din_d   = cpu_wdata;
                        csb_d   = bank_csb(cpu_addr[BANK_MSB:BANK_LSB]);
                        web_d   = ~cpu_rw;
                    end else begin
                        write_d = wbs_we_i;
                        addr_d  = wbs_adr_i[WORD_W+1:2];
                        din_d   = wbs_dat_i[DATA_W-1:0];
                        if (wb_lanes_ok || !wbs_we_i) begin
                            csb_d = bank_csb(wbs_adr_i[BANK_MSB+2:BANK_LSB+2]);
                            web_d = ~wbs_we_i;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (wb_aborted) begin
                    state_d = ST_IDLE;
                end else if (write_q) begin
                    state_d     = ST_RESP;
                    cpu_ready_d = (owner_q == OWNER_CPU);
                    wbs_ack_d   = (owner_q == OWNER_WB);
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (wb_aborted) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                    if (owner_q == OWNER_CPU) begin
                        cpu_rdata_d = mem_dout;
                        cpu_ready_d = 1'b1;
                    end else begin
                        wb_rdata_d = mem_dout;
                        wbs_ack_d  = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All FSM and output registers; reset drops any in-flight access without a handshake.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_CPU;
            write_q     <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            csb_q       <= '1;
            web_q       <= 1'b1;
            cpu_rdata_q <= '0;
            wb_rdata_q  <= '0;
            cpu_ready_q <= 1'b0;
            wbs_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            cpu_rdata_q <= cpu_rdata_d;
            wb_rdata_q  <= wb_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            wbs_ack_q   <= wbs_ack_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign mem_csb   = csb_q;
    assign mem_web   = web_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign wbs_ack_o = wbs_ack_q;
    assign wbs_dat_o = {{(32-DATA_W){1'b0}}, wb_rdata_q};
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: round-robin DUT plus a fixed-priority DUT for the tie case.
module tb_mem_access_arbiter;

    typedef struct packed {
        logic        is_wb;
        logic        chk_data;
        logic        exact;
        logic [31:0] data;
        logic [31:0] cycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc_cnt = 0;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    logic        cpu_en = 1'b0, cpu_rw = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
    logic [3:0]  wbs_sel = '0;
    logic [31:0] wbs_adr = '0, wbs_dat_i = '0;
    logic        fp_cpu_en = 1'b0, fp_wbs_cyc = 1'b0, fp_wbs_stb = 1'b0;

    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        wbs_ack;
    logic [31:0] wbs_dat_o;
    logic [9:0]  mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic [3:0]  mem_csb;
    logic        mem_web;
    logic        busy;

    logic        fp_cpu_ready, fp_wbs_ack;
    logic [15:0] fp_unused_rdata, fp_unused_din;
    logic [31:0] fp_unused_dat_o;
    logic [9:0]  fp_unused_maddr;
    logic [3:0]  fp_unused_csb;
    logic        fp_unused_web, fp_unused_busy;

    logic [15:0] ram [4][1024];

    exp_t  exp_q  [2][$];
    string name_q [2][$];

    mem_access_arbiter #(.WB_BASE(32'h3000_0000), .RR_ARB(1'b1)) dut (
        .wb_clk_i (clk),       .wb_rst_n (rst_n),
        .cpu_en   (cpu_en),    .cpu_rw   (cpu_rw),   .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .wbs_cyc_i(wbs_cyc),   .wbs_stb_i(wbs_stb),  .wbs_we_i (wbs_we),   .wbs_sel_i (wbs_sel),
        .wbs_adr_i(wbs_adr),   .wbs_dat_i(wbs_dat_i),.wbs_ack_o(wbs_ack),  .wbs_dat_o (wbs_dat_o),
        .mem_addr (mem_addr),  .mem_din  (mem_din),  .mem_dout (mem_dout), .mem_csb   (mem_csb),
        .mem_web  (mem_web),   .busy     (busy)
    );

    mem_access_arbiter #(.WB_BASE(32'h3000_0000), .RR_ARB(1'b0)) dut_fp (
        .wb_clk_i (clk),             .wb_rst_n (rst_n),
        .cpu_en   (fp_cpu_en),       .cpu_rw   (cpu_rw),   .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
        .cpu_rdata(fp_unused_rdata), .cpu_ready(fp_cpu_ready),
        .wbs_cyc_i(fp_wbs_cyc),      .wbs_stb_i(fp_wbs_stb), .wbs_we_i (wbs_we), .wbs_sel_i (wbs_sel),
        .wbs_adr_i(wbs_adr),         .wbs_dat_i(wbs_dat_i),  .wbs_ack_o(fp_wbs_ack), .wbs_dat_o(fp_unused_dat_o),
        .mem_addr (fp_unused_maddr), .mem_din  (fp_unused_din), .mem_dout (16'h0000), .mem_csb (fp_unused_csb),
        .mem_web  (fp_unused_web),   .busy     (fp_unused_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Four-bank RAM model: synchronous write, registered read data on a shared bus.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!mem_csb[b]) begin
                if (!mem_web) ram[b][mem_addr] <= mem_din;
                else          mem_dout <= ram[b][mem_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int d, input string name, input logic is_wb, input logic chk,
                           input logic exact, input logic [31:0] data, input int cycle);
        exp_t e;
        e.is_wb    = is_wb;
        e.chk_data = chk;
        e.exact    = exact;
        e.data     = data;
        e.cycle    = 32'(cycle);
        exp_q[d].push_back(e);
        name_q[d].push_back(name);
    endtask

    task automatic scoreResponse(input int d, input logic got_wb, input logic [31:0] got_data);
        exp_t  e;
        string n;
        if (exp_q[d].size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("[TB] FAIL unexpected_resp dut%0d: got %s response at cycle %0d, expected none",
                     d, got_wb ? "wb ack" : "cpu ready", cyc_cnt);
        end else begin
            e = exp_q[d].pop_front();
            n = name_q[d].pop_front();
            checkOutput({n, "_owner"}, 32'(got_wb), 32'(e.is_wb));
            if (e.chk_data) checkOutput({n, "_data"}, got_data, e.data);
            if (e.exact) checkOutput({n, "_cycle"}, 32'(cyc_cnt), e.cycle);
            else         checkOutput({n, "_late"}, 32'(cyc_cnt > int'(e.cycle)), 32'd0);
        end
    endtask

    // Monitor: every handshake pulse is matched against the next expected response.
    always @(negedge clk) begin
        if (cpu_ready)    scoreResponse(0, 1'b0, {16'h0000, cpu_rdata});
        if (wbs_ack)      scoreResponse(0, 1'b1, wbs_dat_o);
        if (fp_cpu_ready) scoreResponse(1, 1'b0, 32'h0);
        if (fp_wbs_ack)   scoreResponse(1, 1'b1, 32'h0);
    end

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        if (busy) checkOutput("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    // One complete access on the main DUT, with ACCESS-cycle bus checks and a bounded handshake wait.
    task automatic applyStimulus(input string name, input logic is_wb, input logic wr,
                                 input logic [31:0] addr, input logic [15:0] wdata, input logic [3:0] sel,
                                 input logic [3:0] exp_csb, input logic [9:0] exp_maddr,
                                 input logic [31:0] exp_rdata);
        int base;
        int n = 0;
        waitIdle();
        base = cyc_cnt;
        if (is_wb) begin
            wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = wr;
            wbs_adr = addr; wbs_dat_i = {16'hDEAD, wdata}; wbs_sel = sel;
        end else begin
            cpu_en = 1'b1; cpu_rw = wr; cpu_addr = addr[11:0]; cpu_wdata = wdata;
        end
        pushExp(0, name, is_wb, !wr, 1'b1, exp_rdata, base + (wr ? 2 : 3));
        tick();
        checkOutput({name, "_csb"}, 32'(mem_csb), 32'(exp_csb));
        checkOutput({name, "_maddr"}, 32'(mem_addr), 32'(exp_maddr));
        while (!(is_wb ? wbs_ack : cpu_ready) && n < 10) begin
            tick();
            n++;
        end
        if (!(is_wb ? wbs_ack : cpu_ready)) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
        tick();
        cpu_en = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  base;
        int  n;
        logic busy2, busy3;

        $display("[TB] reset");
        repeat (3) tick();
        checkOutput("rst_csb",    32'(mem_csb),   32'hF);
        checkOutput("rst_web",    32'(mem_web),   32'd1);
        checkOutput("rst_maddr",  32'(mem_addr),  32'd0);
        checkOutput("rst_din",    32'(mem_din),   32'd0);
        checkOutput("rst_rdata",  32'(cpu_rdata), 32'd0);
        checkOutput("rst_wbdat",  wbs_dat_o,      32'd0);
        checkOutput("rst_hshake", 32'({cpu_ready, wbs_ack}), 32'd0);
        checkOutput("rst_busy",   32'(busy),      32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] directed CPU and Wishbone accesses");
        applyStimulus("cpu_wr_7ff",  1'b0, 1'b1, 32'h0000_07FF, 16'hBEEF, 4'hF, 4'b1101, 10'h3FF, 32'h0);
        applyStimulus("cpu_rd_7ff",  1'b0, 1'b0, 32'h0000_07FF, 16'h0000, 4'hF, 4'b1101, 10'h3FF, 32'h0000_BEEF);
        applyStimulus("wb_wr_008",   1'b1, 1'b1, 32'h3000_0008, 16'h1234, 4'hF, 4'b1110, 10'h002, 32'h0);
        applyStimulus("wb_rd_008",   1'b1, 1'b0, 32'h3000_0008, 16'h0000, 4'hF, 4'b1110, 10'h002, 32'h0000_1234);
        applyStimulus("cpu_wr_fff",  1'b0, 1'b1, 32'h0000_0FFF, 16'hA5A5, 4'hF, 4'b0111, 10'h3FF, 32'h0);
        applyStimulus("cpu_rd_fff",  1'b0, 1'b0, 32'h0000_0FFF, 16'h0000, 4'hF, 4'b0111, 10'h3FF, 32'h0000_A5A5);
        applyStimulus("cpu_rd_7ff2", 1'b0, 1'b0, 32'h0000_07FF, 16'h0000, 4'hF, 4'b1101, 10'h3FF, 32'h0000_BEEF);
        applyStimulus("wb_wr_sel1",  1'b1, 1'b1, 32'h3000_0008, 16'h5555, 4'b0001, 4'b1111, 10'h002, 32'h0);
        applyStimulus("wb_rd_old",   1'b1, 1'b0, 32'h3000_0008, 16'h0000, 4'hF, 4'b1110, 10'h002, 32'h0000_1234);

        $display("[TB] contention: round-robin and fixed priority");
        waitIdle();
        base = cyc_cnt;
        cpu_en = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h020; cpu_wdata = 16'h1111;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_sel = 4'hF;
        wbs_adr = 32'h3000_0040; wbs_dat_i = 32'h0000_2222;
        fp_cpu_en = 1'b1; fp_wbs_cyc = 1'b1; fp_wbs_stb = 1'b1;
        pushExp(0, "rr_g0", 1'b0, 1'b0, 1'b1, 32'h0, base + 2);
        pushExp(0, "rr_g1", 1'b1, 1'b0, 1'b1, 32'h0, base + 5);
        pushExp(0, "rr_g2", 1'b0, 1'b0, 1'b1, 32'h0, base + 8);
        pushExp(0, "rr_g3", 1'b1, 1'b0, 1'b1, 32'h0, base + 11);
        pushExp(1, "fp_g0", 1'b0, 1'b0, 1'b1, 32'h0, base + 2);
        pushExp(1, "fp_g1", 1'b0, 1'b0, 1'b1, 32'h0, base + 5);
        pushExp(1, "fp_g2", 1'b0, 1'b0, 1'b1, 32'h0, base + 8);
        pushExp(1, "fp_g3", 1'b0, 1'b0, 1'b1, 32'h0, base + 11);
        repeat (12) tick();
        cpu_en = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
        fp_cpu_en = 1'b0; fp_wbs_cyc = 1'b0; fp_wbs_stb = 1'b0;
        tick();

        $display("[TB] Wishbone abort with CPU pending");
        waitIdle();
        base = cyc_cnt;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_sel = 4'hF; wbs_adr = 32'h3000_0008;
        tick();
        checkOutput("abort_csb", 32'(mem_csb), 32'b1110);
        wbs_cyc = 1'b0;
        cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h7FF;
        pushExp(0, "abort_cpu_rd", 1'b0, 1'b1, 1'b0, 32'h0000_BEEF, base + 6);
        tick();
        busy2 = busy;
        tick();
        busy3 = busy;
        checkOutput("abort_idle_by_3", 32'(busy2 & busy3), 32'd0);
        n = 0;
        while (!cpu_ready && n < 10) begin
            tick();
            n++;
        end
        if (!cpu_ready) checkOutput("abort_cpu_timeout", 32'd0, 32'd1);
        tick();
        cpu_en = 1'b0; wbs_stb = 1'b0;

        $display("[TB] reset during CAPTURE, then out-of-window access");
        waitIdle();
        cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h7FF;
        tick();
        tick();
        checkOutput("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        cpu_en = 1'b0;
        tick();
        checkOutput("midrst_busy",  32'(busy),      32'd0);
        checkOutput("midrst_csb",   32'(mem_csb),   32'hF);
        checkOutput("midrst_rdy",   32'(cpu_ready), 32'd0);
        checkOutput("midrst_rdata", 32'(cpu_rdata), 32'd0);
        rst_n = 1'b1;
        tick();
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_sel = 4'hF; wbs_adr = 32'h3100_0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("oow_busy", 32'(busy), 32'd0);
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0;

        repeat (4) tick();
        checkOutput("leftover_main", 32'(exp_q[0].size()), 32'd0);
        checkOutput("leftover_fp",   32'(exp_q[1].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
